// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: frame tick, start button and ball dynamics in; serve control, scores and sound out.
interface pong_match_ctrl_if;
  logic       tick;
  logic       start;
  logic [9:0] x_ball;
  logic       hit;
  logic       ball_hold;
  logic       ball_run;
  logic       serve_left;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [2:0] state;
  logic       game_over;
  logic       mute;
  logic [1:0] code_sound;

  modport master (
    output tick, start, x_ball, hit,
    input  ball_hold, ball_run, serve_left, score1, score2, state, game_over, mute, code_sound
  );

  modport slave (
    input  tick, start, x_ball, hit,
    output ball_hold, ball_run, serve_left, score1, score2, state, game_over, mute, code_sound
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve hold, goal detection, scoring, match end and sound cueing.
module pong_match_ctrl #(
  parameter int unsigned GOAL_L      = 0,
  parameter int unsigned GOAL_R      = 630,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned GOAL_TICKS  = 90,
  parameter int unsigned SND_TICKS   = 8
) (
  input logic              clk,
  input logic              clr,
  pong_match_ctrl_if.slave bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned SW = 4;
  localparam int unsigned TW = 8;

  localparam logic [XW-1:0] GOAL_L_C     = XW'(GOAL_L);
  localparam logic [XW-1:0] GOAL_R_C     = XW'(GOAL_R);
  localparam logic [SW-1:0] WIN_C        = SW'(WIN_SCORE);
  localparam logic [TW-1:0] SERVE_LAST_C = TW'(SERVE_TICKS - 1);
  localparam logic [TW-1:0] GOAL_LAST_C  = TW'(GOAL_TICKS - 1);
  localparam logic [TW-1:0] SND_LOAD_C   = TW'(SND_TICKS);

  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_GO   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] snd_timer_q, snd_timer_d;
  logic [SW-1:0] score1_q, score1_d;
  logic [SW-1:0] score2_q, score2_d;
  logic          serve_left_q, serve_left_d;
  logic          ball_hold_q, ball_hold_d;
  logic          ball_run_q, ball_run_d;
  logic          game_over_q, game_over_d;
  logic          mute_q, mute_d;
  logic [1:0]    code_q, code_d;
  // Set when start was low on the previous clk; resets clear so a held button is not a press.
  logic          start_low_q, start_low_d;

  logic start_rise;
  logic fire_go, fire_pong, fire_ping;

  assign start_rise = bus.start & start_low_q;

  // Next-state, timers, scores, sound and registered output values.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    serve_left_d = serve_left_q;
    snd_timer_d  = snd_timer_q;
    mute_d       = mute_q;
    code_d       = code_q;
    fire_go      = 1'b0;
    fire_pong    = 1'b0;
    fire_ping    = 1'b0;
    start_low_d  = ~bus.start;

    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          score1_d = '0;
          score2_d = '0;
          timer_d  = '0;
          state_d  = SERVE;
          fire_go  = 1'b1;
        end
      end
      SERVE: begin
        if (bus.tick) begin
          if (timer_q == SERVE_LAST_C) begin
            timer_d = '0;
            state_d = PLAY;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      PLAY: begin
        if (bus.x_ball <= GOAL_L_C) begin
          score2_d     = (score2_q >= WIN_C) ? WIN_C : score2_q + SW'(1);
          serve_left_d = 1'b1;
          timer_d      = '0;
          state_d      = GOAL;
          fire_pong    = 1'b1;
        end else if (bus.x_ball >= GOAL_R_C) begin
          score1_d     = (score1_q >= WIN_C) ? WIN_C : score1_q + SW'(1);
          serve_left_d = 1'b0;
          timer_d      = '0;
          state_d      = GOAL;
          fire_pong    = 1'b1;
        end else if (bus.hit) begin
          fire_ping = 1'b1;
        end
      end
      GOAL: begin
        if (bus.tick) begin
          if (timer_q == GOAL_LAST_C) begin
            timer_d = '0;
            state_d = (score1_q == WIN_C || score2_q == WIN_C) ? OVER : SERVE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    if (fire_go || fire_pong || fire_ping) begin
      code_d      = fire_go ? SND_GO : (fire_pong ? SND_PONG : SND_PING);
      snd_timer_d = SND_LOAD_C;
      mute_d      = 1'b0;
    end else if (bus.tick && snd_timer_q != '0) begin
      snd_timer_d = snd_timer_q - TW'(1);
      if (snd_timer_q == TW'(1)) begin
        mute_d = 1'b1;
        code_d = SND_STOP;
      end
    end

    ball_hold_d = !(state_d == PLAY || state_d == GOAL);
    ball_run_d  = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  // State and output registers; clr aborts any match back to IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      snd_timer_q  <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      serve_left_q <= 1'b0;
      ball_hold_q  <= 1'b1;
      ball_run_q   <= 1'b0;
      game_over_q  <= 1'b0;
      mute_q       <= 1'b1;
      code_q       <= SND_STOP;
      start_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      snd_timer_q  <= snd_timer_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      serve_left_q <= serve_left_d;
      ball_hold_q  <= ball_hold_d;
      ball_run_q   <= ball_run_d;
      game_over_q  <= game_over_d;
      mute_q       <= mute_d;
      code_q       <= code_d;
      start_low_q  <= start_low_d;
    end
  end

  assign bus.ball_hold  = ball_hold_q;
  assign bus.ball_run   = ball_run_q;
  assign bus.serve_left = serve_left_q;
  assign bus.score1     = score1_q;
  assign bus.score2     = score2_q;
  assign bus.state      = state_q;
  assign bus.game_over  = game_over_q;
  assign bus.mute       = mute_q;
  assign bus.code_sound = code_q;

endmodule
